// File: rtl/fifo_pkg.sv
// Shared sizing helpers and output-buffer occupancy encoding for the BRAM FIFO.
package fifo_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   // Room for DEPTH BRAM words plus the 2-entry output buffer.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return clog2(depth + 3);
   endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port with
// an optional extra output register stage.
module sdp_bram
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = 512,
   parameter bit          LOW_LATENCY = 1'b1
) (
   input  logic                      clk,
   input  logic                      ena,
   input  logic                      wea,
   input  logic [clog2(DEPTH)-1:0]   addra,
   input  logic [WIDTH-1:0]          dina,
   input  logic                      rstb,
   input  logic                      enb,
   input  logic [clog2(DEPTH)-1:0]   addrb,
   input  logic                      oreg_enb,
   output logic [WIDTH-1:0]          doutb
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_q;
   logic [WIDTH-1:0] oreg_q;

   always_ff @(posedge clk) begin
      if (ena && wea)
         mem[addra] <= dina;
   end

   // Only the read registers see reset; array contents survive it.
   always_ff @(posedge clk) begin
      if (rstb)
         ram_q <= '0;
      else if (enb)
         ram_q <= mem[addrb];
   end

   always_ff @(posedge clk) begin
      if (rstb)
         oreg_q <= '0;
      else if (oreg_enb)
         oreg_q <= ram_q;
   end

   assign doutb = LOW_LATENCY ? ram_q : oreg_q;

endmodule

// File: rtl/bram_fifo.sv
// Valid/ready FIFO backed by a BRAM with a 2-entry register output buffer,
// giving DEPTH+2 words of capacity and full throughput.
module bram_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 512
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [WIDTH-1:0]              s_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [WIDTH-1:0]              m_data,
   output logic [cnt_width(DEPTH)-1:0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    ram_cnt;
   logic             inflight;
   occ_e             occ;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic [CW-1:0]    count_q;

   logic             push;
   logic             pop;
   logic             rd_issue;
   logic [WIDTH-1:0] rd_data;
   logic [1:0]       occ_cnt;
   logic [1:0]       occ_cnt_n;
   logic [CW-1:0]    ram_cnt_n;
   logic [CW-1:0]    count_n;
   logic [WIDTH-1:0] head_n;
   logic [WIDTH-1:0] tail_n;

   assign s_ready = (ram_cnt < CW'(DEPTH));
   assign m_valid = (occ != EMPTY);
   assign m_data  = head_q;
   assign count   = count_q;
   assign full    = !s_ready;
   assign empty   = (count_q == '0);

   // The buffer is first drained by a pop, then the returning read word
   // lands in the first free slot, so a pop and a load may share one edge.
   always_comb begin
      push      = s_valid && s_ready;
      pop       = m_valid && m_ready;
      occ_cnt   = occ;
      rd_issue  = (ram_cnt != '0) &&
                  ((3'(occ_cnt) + 3'(inflight) - 3'(pop)) < 3'd2);
      ram_cnt_n = ram_cnt + CW'(push) - CW'(rd_issue);
      head_n    = head_q;
      tail_n    = tail_q;
      occ_cnt_n = occ_cnt;
      if (pop) begin
         head_n    = tail_q;
         occ_cnt_n = occ_cnt - 2'd1;
      end
      if (inflight) begin
         if (occ_cnt_n == 2'd0)
            head_n = rd_data;
         else
            tail_n = rd_data;
         occ_cnt_n = occ_cnt_n + 2'd1;
      end
      count_n = ram_cnt_n + CW'(rd_issue) + CW'(occ_cnt_n);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         occ      <= EMPTY;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_issue)
            rd_ptr <= rd_ptr + AW'(1);
         ram_cnt  <= ram_cnt_n;
         inflight <= rd_issue;
         occ      <= occ_e'(occ_cnt_n);
         head_q   <= head_n;
         tail_q   <= tail_n;
         count_q  <= count_n;
      end
   end

   sdp_bram #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .LOW_LATENCY (1'b1)
   ) u_ram (
      .clk      (clk),
      .ena      (push),
      .wea      (push),
      .addra    (wr_ptr),
      .dina     (s_data),
      .rstb     (rst),
      .enb      (rd_issue),
      .addrb    (rd_ptr),
      .oreg_enb (1'b0),
      .doutb    (rd_data)
   );

endmodule

// File: tb/tb_bram_fifo.sv
// Scoreboard bench for bram_fifo at DEPTH=8: accepted words are queued,
// an independent monitor checks every popped word and hold stability.
module tb_bram_fifo;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = fifo_pkg::cnt_width(DEPTH);

   logic             clk;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;

   int               n_cmp = 0;
   int               n_bad = 0;
   int               pop_cnt = 0;
   logic [WIDTH-1:0] exp_q [$];
   logic             hold_prev = 1'b0;
   logic [WIDTH-1:0] hold_data = '0;

   bram_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Stimulus side of the scoreboard: record every accepted word.
   always @(negedge clk) begin
      if (rst)
         exp_q.delete();
      else if (s_valid && s_ready)
         exp_q.push_back(s_data);
   end

   // Output monitor: check popped words and stability under backpressure.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_data", 64'(m_data), 64'(hold_data));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_pop: got 0x%0h expected no word", m_data);
            end else begin
               chk("pop_data", 64'(m_data), 64'(exp_q.pop_front()));
               pop_cnt++;
            end
         end
         hold_prev = m_valid && !m_ready;
         hold_data = m_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      m_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      m_ready = 1'b0;
      chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_empty"}, 64'(empty), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int drops;
      int idx;
      int cyc;
      logic acc;

      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      step();

      // Single word: reset values, 2-edge latency, pop to empty
      do_reset();
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      s_valid = 1'b1; s_data = 32'hA5A5A5A5;
      step();
      s_valid = 1'b0; s_data = 32'hDEADBEEF;
      chk("t1_mvalid_e0", 64'(m_valid), 64'd0);
      chk("t1_count_e0", 64'(count), 64'd1);
      step();
      chk("t1_mvalid_e1", 64'(m_valid), 64'd0);
      step();
      chk("t1_mvalid_e2", 64'(m_valid), 64'd1);
      chk("t1_mdata_e2", 64'(m_data), 64'hA5A5A5A5);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("t1_empty", 64'(empty), 64'd1);
      chk("t1_count", 64'(count), 64'd0);
      chk("t1_mvalid_after", 64'(m_valid), 64'd0);

      // Fill to DEPTH+2, refused push, then full-boundary push+pop
      do_reset();
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1; s_data = 32'h100 + 32'(i);
         step();
      end
      chk("t2_full", 64'(full), 64'd1);
      chk("t2_count", 64'(count), 64'd10);
      chk("t2_s_ready", 64'(s_ready), 64'd0);
      s_data = 32'h1FF;
      step();
      chk("t2_refused_count", 64'(count), 64'd10);
      chk("t2_refused_full", 64'(full), 64'd1);
      s_data = 32'h2FF; m_ready = 1'b1;
      step();
      s_valid = 1'b0; m_ready = 1'b0;
      chk("t2_bnd_s_ready", 64'(s_ready), 64'd1);
      chk("t2_bnd_count", 64'(count), 64'd9);
      drain("t2");

      // Streaming 0..999 with m_ready held
      do_reset();
      m_ready = 1'b1;
      p0 = pop_cnt;
      drops = 0;
      for (int i = 0; i < 1000; i++) begin
         s_valid = 1'b1; s_data = 32'(i);
         @(negedge clk);
         if (!s_ready) drops++;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      step();
      step();
      chk("t3_pops_e1001", 64'(pop_cnt - p0), 64'd999);
      step();
      chk("t3_pops_e1002", 64'(pop_cnt - p0), 64'd1000);
      chk("t3_sready_drops", 64'(drops), 64'd0);
      chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
      m_ready = 1'b0;

      // Wrap and random backpressure, 3*DEPTH words
      do_reset();
      p0 = pop_cnt;
      idx = 0;
      cyc = 0;
      while (idx < 3 * int'(DEPTH) && cyc < 2000) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = 32'h5000 + 32'(idx);
         m_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
         cyc++;
      end
      s_valid = 1'b0;
      chk("t4_pushed", 64'(idx), 64'(3 * DEPTH));
      drain("t4");
      chk("t4_pops", 64'(pop_cnt - p0), 64'(3 * DEPTH));

      // Reset mid-stream with count=5 and a read in flight
      do_reset();
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_data = 32'h700 + 32'(i);
         step();
      end
      s_data = 32'h705; m_ready = 1'b1;
      step();
      chk("t5_count_pre", 64'(count), 64'd5);
      rst = 1'b1; s_valid = 1'b1; s_data = 32'h7FF; m_ready = 1'b1;
      step();
      rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      chk("t5_m_valid", 64'(m_valid), 64'd0);
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_s_ready", 64'(s_ready), 64'd1);
      chk("t5_empty", 64'(empty), 64'd1);
      step();
      chk("t5_no_stale_load", 64'(m_valid), 64'd0);
      chk("t5_count_late", 64'(count), 64'd0);
      s_valid = 1'b1; s_data = 32'h1;
      step();
      s_valid = 1'b0;
      cyc = 0;
      while (!m_valid && cyc < 20) begin
         step();
         cyc++;
      end
      chk("t5_first_valid", 64'(m_valid), 64'd1);
      chk("t5_first_data", 64'(m_data), 64'd1);
      drain("t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
